// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, one round per clock, 21 edges start-to-result.
// Ports: clk, rst (async active-low), start, d_in, key_in -> d_out, d_vld, busy.
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] d_in,
    input  logic [127:0] key_in,
    output logic [127:0] d_out,
    output logic         d_vld,
    output logic         busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_KEYEXP, S_ARK0, S_ROUND, S_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] d_out_q, d_out_d;
    logic         d_vld_q, d_vld_d;
    logic         busy_q, busy_d;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // datapath: InvShiftRows then 16 inverse S-boxes
    logic [127:0] isr, isb, ark, imc;

    always_comb begin
        isr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isr[127-8*(4*c+r) -: 8] =
                    st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
    end

    for (genvar i = 0; i < 16; i++) begin : g_isb
        aes_inv_sbox u_isb (
            .a (isr[127-8*i -: 8]),
            .y (isb[127-8*i -: 8])
        );
    end

    assign ark = isb ^ key_q;

    always_comb begin
        imc = '0;
        for (int c = 0; c < 4; c++)
            imc[127-32*c -: 32] = imc_col(ark[127-32*c -: 32]);
    end

    // key schedule: the four forward S-boxes are shared between the
    // forward step (fed w3) and the inverse step (fed the recovered w3)
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] pw1, pw2, pw3, pw0;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] sb_in, sb_rot, sb_out, rc_w;
    logic [127:0] key_fwd, key_inv;

    assign w0     = key_q[127:96];
    assign w1     = key_q[95:64];
    assign w2     = key_q[63:32];
    assign w3     = key_q[31:0];
    assign pw3    = w3 ^ w2;
    assign pw2    = w2 ^ w1;
    assign pw1    = w1 ^ w0;
    assign sb_in  = (fsm_q == S_KEYEXP) ? w3 : pw3;
    assign sb_rot = {sb_in[23:0], sb_in[31:24]};
    // ARK0 sits at cnt=11 but undoes the last expansion step
    assign rc_w   = {rcon((fsm_q == S_ARK0) ? 4'd10 : cnt_q), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes_sbox u_ksb (
            .a (sb_rot[31-8*i -: 8]),
            .y (sb_out[31-8*i -: 8])
        );
    end

    assign n0      = w0 ^ sb_out ^ rc_w;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign key_fwd = {n0, n1, n2, n3};
    assign pw0     = w0 ^ sb_out ^ rc_w;
    assign key_inv = {pw0, pw1, pw2, pw3};

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        key_d   = key_q;
        d_out_d = d_out_q;
        d_vld_d = d_vld_q;
        unique case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    st_d    = d_in;
                    key_d   = key_in;
                    cnt_d   = 4'd1;
                    d_vld_d = 1'b0;
                    fsm_d   = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                key_d = key_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) fsm_d = S_ARK0;
            end
            S_ARK0: begin
                st_d  = st_q ^ key_q;
                key_d = key_inv;
                cnt_d = 4'd9;
                fsm_d = S_ROUND;
            end
            S_ROUND: begin
                if (cnt_q == 4'd0) begin
                    d_out_d = ark;
                    d_vld_d = 1'b1;
                    fsm_d   = S_DONE;
                end else begin
                    st_d  = imc;
                    key_d = key_inv;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        busy_d = (fsm_d == S_KEYEXP) || (fsm_d == S_ARK0) ||
                 (fsm_d == S_ROUND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            d_out_q <= '0;
            d_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            d_out_q <= d_out_d;
            d_vld_q <= d_vld_d;
            busy_q  <= busy_d;
        end
    end

    assign d_out = d_out_q;
    assign d_vld = d_vld_q;
    assign busy  = busy_q;
endmodule

// Multiplicative inverse in GF(2^8) as a^254 (0 maps to 0).
module aes_gf_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gm(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] r, x;
        r = '0;
        x = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    logic [7:0] s3, s7, s15, s31, s63, s127;
    assign s3   = gm(gm(a, a), a);
    assign s7   = gm(gm(s3, s3), a);
    assign s15  = gm(gm(s7, s7), a);
    assign s31  = gm(gm(s15, s15), a);
    assign s63  = gm(gm(s31, s31), a);
    assign s127 = gm(gm(s63, s63), a);
    assign y    = gm(s127, s127);
endmodule

// Forward S-box: inverse then affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] v;
    aes_gf_inv u_inv (.a(a), .y(v));
    assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
               {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform then inverse.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;
    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^
               {a[1:0], a[7:2]} ^ 8'h05;
    aes_gf_inv u_inv (.a(t), .y(y));
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: known-answer vectors, latency,
// busy window, start-while-busy, DONE restart, async reset abort.
module tb_aes_inv_cipher;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] d_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] d_out;
    logic         d_vld;
    logic         busy;

    aes_inv_cipher dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .d_in   (d_in),
        .key_in (key_in),
        .d_out  (d_out),
        .d_vld  (d_vld),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic [127:0] tk [10];
    logic [127:0] tc [10];
    logic [127:0] tp [10];

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // drive a start pulse; returns #1 after the sampling edge E0
    task automatic start_op(input logic [127:0] k, input logic [127:0] d);
        @(negedge clk);
        key_in = k;
        d_in   = d;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = ~k;
        d_in   = ~d;
    endtask

    // follow an operation from E0 to d_vld; inputs scrambled while busy,
    // optional start injection before edge inj
    task automatic wait_op(input string tag, input logic [127:0] exp,
                           input logic [127:0] old, input int inj);
        int lat;
        int busy_n;
        int hold_bad;
        lat = 0;
        busy_n = 0;
        hold_bad = 0;
        check($sformatf("%s_vld_clr", tag), {127'b0, d_vld}, 128'd0);
        for (int e = 1; e <= 30 && lat == 0; e++) begin
            @(negedge clk);
            if (e == inj) begin
                start  = 1'b1;
                key_in = K2;
                d_in   = C2;
            end else begin
                key_in = rnd128();
                d_in   = rnd128();
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (d_vld) lat = e;
            else begin
                if (busy) busy_n++;
                if (d_out !== old) hold_bad++;
            end
        end
        check($sformatf("%s_lat", tag), 128'(lat), 128'd21);
        check($sformatf("%s_busy_n", tag), 128'(busy_n), 128'd20);
        check($sformatf("%s_hold", tag), 128'(hold_bad), 128'd0);
        check($sformatf("%s_dout", tag), d_out, exp);
        check($sformatf("%s_busy_end", tag), {127'b0, busy}, 128'd0);
    endtask

    logic [127:0] prev;
    int           vld_seen;
    int           bad0;
    int           v6_pass;

    initial begin
        tk[0] = K1; tc[0] = C1; tp[0] = P1;
        tk[1] = K2; tc[1] = C2; tp[1] = P2;
        tk[2] = K2;
        tc[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        tp[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
        tk[3] = K2;
        tc[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        tp[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        tk[4] = K2;
        tc[4] = 128'h43b1cd7f598ece23881b00e3ed030688;
        tp[4] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        tk[5] = K2;
        tc[5] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        tp[5] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        tk[6] = '0;
        tc[6] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        tp[6] = '0;
        tk[7] = '0;
        tc[7] = 128'h0336763e966d92595a567cc9ce537f5e;
        tp[7] = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
        tk[8] = '0;
        tc[8] = 128'ha9a1631bf4996954ebc093957b234589;
        tp[8] = 128'h9798c4640bad75c7c3227db910174e72;
        tk[9] = '0;
        tc[9] = 128'hff4f8391a6a40ca5b25d23bedd44a597;
        tp[9] = 128'h96ab5c2ff612d9dfaae8c31f30c42168;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", d_out, 128'd0);
        check("rst_vld", {127'b0, d_vld}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // V1, then V2 restarted from DONE
        start_op(K1, C1);
        wait_op("v1", P1, 128'd0, 0);
        start_op(K2, C2);
        wait_op("v2", P2, P1, 0);

        // V3: start with V2 data at edge 5 is ignored
        start_op(K1, C1);
        wait_op("v3", P1, P2, 5);

        // V4: DONE holds, then restart with V2
        repeat (5) @(posedge clk);
        #1;
        check("v4_hold_dout", d_out, P1);
        check("v4_hold_vld", {127'b0, d_vld}, 128'd1);
        start_op(K2, C2);
        wait_op("v4", P2, P1, 0);

        // V5: reset at edge 15 of V2, start held through release
        start_op(K2, C2);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("v5_dout", d_out, 128'd0);
        check("v5_vld", {127'b0, d_vld}, 128'd0);
        check("v5_busy", {127'b0, busy}, 128'd0);
        start  = 1'b1;
        key_in = K1;
        d_in   = C1;
        vld_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (d_vld || busy) vld_seen++;
        end
        check("v5_in_rst", 128'(vld_seen), 128'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = rnd128();
        d_in   = rnd128();
        wait_op("v5_v1", P1, 128'd0, 0);

        // V6: ten vectors back to back
        prev = P1;
        v6_pass = 0;
        for (int i = 0; i < 10; i++) begin
            bad0 = n_bad;
            start_op(tk[i], tc[i]);
            wait_op($sformatf("v6_%0d", i), tp[i], prev, 0);
            if (n_bad == bad0) v6_pass++;
            prev = tp[i];
        end
        check("v6_pass", 128'(v6_pass), 128'd10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have no parameters; AES-128 only, 128-bit block and key.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 d_in  input  128  ciphertext; byte 0 at [127:120]; sampled on the start edge only.
REQ-006 key_in  input  128  cipher key; byte 0 at [127:120]; sampled on the start edge only.
REQ-007 d_out  output  128  recovered plaintext, registered.
REQ-008 d_vld  output  1  high while d_out holds a completed result.
REQ-009 busy  output  1  high in KEYEXP, ARK0 and ROUND.

Function
REQ-010 SHALL implement the FIPS-197 inverse cipher for Nk=4, Nr=10.
- InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; one round per cycle.
REQ-011 SHALL use a 4-bit round counter and the FSM states IDLE, KEYEXP, ARK0, ROUND, DONE.
REQ-012 IDLE/DONE with start=1 at edge E0 SHALL do all of the following, then go to KEYEXP:
- load state <= d_in, key <= key_in, cnt <= 1;
- clear d_vld.
REQ-013 KEYEXP (E1..E10) SHALL apply the forward key-schedule step with Rcon[cnt] and increment cnt; after E10 key = rk10, then go to ARK0.
REQ-014 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte of the word.
REQ-015 ARK0 (E11) SHALL do all of the following, then go to ROUND:
- state <= state ^ rk10;
- key <= rk9 via the inverse step with Rcon[10];
- cnt <= 9.
REQ-016 Inverse key step from rk_i (words w4..w7) with Rcon[i]:
- w1=w5^w4, w2=w6^w5, w3=w7^w6;
- w0=w4^SubWord(RotWord(w3))^Rcon[i].
REQ-017 ROUND with cnt=i, i=9..1 (E12..E20):
- state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key);
- key <= rk_{i-1} using Rcon[i];
- cnt <= i-1.
REQ-018 ROUND with cnt=0 (E21): d_out <= InvSubBytes(InvShiftRows(state)) ^ rk0, d_vld <= 1, go to DONE.
REQ-019 Latency SHALL be exactly 21 rising edges from the start-sampling edge to d_vld high, with no input dependence.
REQ-020 start while busy SHALL be ignored; d_in/key_in changes while busy SHALL NOT affect the result.
REQ-021 In DONE:
- d_out and d_vld SHALL hold until start or reset;
- start in DONE SHALL clear d_vld at that edge and begin a new operation per REQ-012;
- d_out SHALL keep the old value until the new result is written.
REQ-022 SHALL instantiate the existing byte-substitution leaf tables: 16 inverse S-boxes for the datapath and 4 forward S-boxes for the key step.
REQ-023 InvMixColumns SHALL use GF(2^8) multiplication by 09,0B,0D,0E modulo x^8+x^4+x^3+x+1, implemented combinationally with xtime.

Reset
REQ-024 rst=0 SHALL immediately force all of the following: FSM IDLE, d_out=0, d_vld=0, busy=0, cnt=0, state/key registers 0.
REQ-025 Reset mid-operation SHALL abort the operation.
- No partial result SHALL appear.
- After release, the block SHALL wait for start.
REQ-026 start held high during reset release SHALL be sampled only on the first rising edge with rst=1.

Verification
REQ-027 Directed scenarios:
- V1: key 000102030405060708090a0b0c0d0e0f, d_in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> d_vld at edge 21, d_out 00112233445566778899aabbccddeeff.
- V2: key 2b7e151628aed2a6abf7158809cf4f3c, d_in 3925841d02dc09fbdc118597196a0b32 -> d_out 3243f6a8885a308d313198a2e0370734; busy high on edges 1..20 only.
- V3: V1 running; at edge 5 drive start=1 with V2 data -> ignored; V1 result delivered at edge 21.
- V4: V1 in DONE; start with V2 data -> d_vld low on the next edge; V2 result 21 edges later; d_out shows the V1 value until then.
- V5: assert rst low at edge 15 of V2 -> d_out=0 and d_vld=0 asynchronously, no d_vld pulse; after release, V1 runs to the correct result.
- V6: back-to-back: start re-issued the cycle after d_vld rises, 10 vectors from file, all cipher/key/plaintext triples -> 10/10 pass.
